// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and a per-tenure
// hold limit that forces rotation when other requesters are waiting.
module ring_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 preempt,
    output logic                 dbg_state
);

    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [N-1:0]  PTR_RST   = N'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           valid_q;
    logic [IDW-1:0] id_q, id_d;
    logic           preempt_q, preempt_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic [N-1:0]   others;
    logic           holder_req;
    logic [N-1:0]   next_ptr;

    // First set bit of r at or above the one-hot position p, wrapping N-1 -> 0.
    function automatic logic [N-1:0] pick(input logic [N-1:0] r, input logic [N-1:0] p);
        logic [N-1:0] res;
        logic         found;
        int           base;
        int           pos;
        res   = '0;
        found = 1'b0;
        base  = 0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) base = i;
        end
        for (int k = 0; k < N; k++) begin
            pos = base + k;
            if (pos >= N) pos = pos - N;
            if (!found && r[pos]) begin
                res[pos] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [IDW-1:0] to_bin(input logic [N-1:0] g);
        logic [IDW-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) b = IDW'(i);
        end
        return b;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_RST;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            valid_q   <= |grant_d;
            id_q      <= id_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
        end
    end

    assign others     = req & ~grant_q;
    assign holder_req = |(req & grant_q);
    // Rotating past the holder makes it the lowest priority for the next pick.
    assign next_ptr   = {grant_q[N-2:0], grant_q[N-1]};

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        preempt_d = 1'b0;
        hold_d    = hold_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = pick(req, ptr_q);
                    state_d = S_GRANT;
                    hold_d  = '0;
                end
            end
            S_GRANT: begin
                if (!holder_req) begin
                    ptr_d  = next_ptr;
                    hold_d = '0;
                    if (|others) begin
                        grant_d = pick(others, next_ptr);
                    end else begin
                        grant_d = '0;
                        state_d = S_IDLE;
                    end
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (|others) begin
                        grant_d   = pick(others, next_ptr);
                        ptr_d     = next_ptr;
                        preempt_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
        id_d = to_bin(grant_d);
    end

    always_comb begin
        grant       = grant_q;
        grant_valid = valid_q;
        grant_id    = id_q;
        preempt     = preempt_q;
        dbg_state   = state_q;
    end

endmodule
